pulse_channel: RTL and testbench

- Square-wave tone generator for one audio voice. Produces a 4-bit unsigned amplitude sample every clock.
- The sample is consumed by the channel mixer, which sums voices into the 6-bit unsigned word driving the delta-modulation PWM stage.
- Contains a programmable period timer, an 8-step duty sequencer, a decaying volume envelope and a length counter.
- Controlled through a 4-register byte write port.

---
 rtl/pulse_channel_if.sv | 21 ++
 rtl/pulse_channel.sv | 108 ++++++++++
 tb/tb_pulse_channel.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_channel_if.sv
// Register write port, envelope/length strobes and sample output of one pulse voice.
// The controller side drives the strobes and writes; the channel returns sample and active.
interface pulse_channel_if;
  logic       quarter_tick;
  logic       half_tick;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_data;
  logic [3:0] sample;
  logic       active;

  modport master (
    output quarter_tick, half_tick, reg_we, reg_addr, reg_data,
    input  sample, active
  );

  modport slave (
    input  quarter_tick, half_tick, reg_we, reg_addr, reg_data,
    output sample, active
  );
endinterface

// File: rtl/pulse_channel.sv
// Square-wave voice: period timer, 8-step duty sequencer, decaying envelope and length counter.
// Produces a registered 4-bit amplitude every clock.
module pulse_channel #(
  parameter int TIMER_WIDTH = 11,
  parameter int MIN_PERIOD  = 8
) (
  input logic             clk,
  input logic             rst,
  pulse_channel_if.slave  bus
);

  logic [1:0]             duty;
  logic                   halt;
  logic                   const_vol;
  logic [3:0]             vol;
  logic [TIMER_WIDTH-1:0] period;
  logic                   enable;
  logic [TIMER_WIDTH-1:0] timer;
  logic [2:0]             step;
  logic                   start;
  logic [3:0]             divider;
  logic [3:0]             decay;
  logic [5:0]             length;

  logic                   wr0, wr1, wr2, wr3;
  logic [7:0]             pattern;
  logic [3:0]             level;

  assign wr0 = bus.reg_we && (bus.reg_addr == 2'd0);
  assign wr1 = bus.reg_we && (bus.reg_addr == 2'd1);
  assign wr2 = bus.reg_we && (bus.reg_addr == 2'd2);
  assign wr3 = bus.reg_we && (bus.reg_addr == 2'd3);

  always_comb begin
    pattern = 8'b0000_0010;
    case (duty)
      2'd0: pattern = 8'b0000_0010;
      2'd1: pattern = 8'b0000_0110;
      2'd2: pattern = 8'b0001_1110;
      2'd3: pattern = 8'b1111_1001;
      default: pattern = 8'b0000_0010;
    endcase
  end

  // Short periods are muted but the timer and sequencer keep running.
  always_comb begin
    level = 4'd0;
    if (length != 6'd0 && period >= TIMER_WIDTH'(MIN_PERIOD) && pattern[step])
      level = const_vol ? vol : decay;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty       <= 2'd0;
      halt       <= 1'b0;
      const_vol  <= 1'b0;
      vol        <= 4'd0;
      period     <= '0;
      enable     <= 1'b0;
      timer      <= '0;
      step       <= 3'd0;
      start      <= 1'b0;
      divider    <= 4'd0;
      decay      <= 4'd0;
      length     <= 6'd0;
      bus.sample <= 4'd0;
      bus.active <= 1'b0;
    end else begin
      if (wr0) {duty, halt, const_vol, vol} <= bus.reg_data;
      if (wr1) period[7:0] <= bus.reg_data;
      if (wr2) period[TIMER_WIDTH-1:8] <= bus.reg_data[TIMER_WIDTH-9:0];
      if (wr3) enable <= bus.reg_data[0];

      // A period change only lands at the next reload.
      if (timer == '0) timer <= period;
      else             timer <= timer - TIMER_WIDTH'(1);

      if (wr2)               step <= 3'd0;
      else if (timer == '0)  step <= step + 3'd1;

      // The envelope sees the start flag as it was before this cycle's write.
      if (bus.quarter_tick) begin
        if (start) begin
          decay   <= 4'd15;
          divider <= vol;
        end else if (divider == 4'd0) begin
          divider <= vol;
          if (decay != 4'd0) decay <= decay - 4'd1;
          else if (halt)     decay <= 4'd15;
        end else begin
          divider <= divider - 4'd1;
        end
      end

      if (wr2)                                start <= 1'b1;
      else if (bus.quarter_tick && start)     start <= 1'b0;

      if (wr3 && !bus.reg_data[0])            length <= 6'd0;
      else if (wr2 && enable)                 length <= {bus.reg_data[7:3], 1'b1};
      else if (bus.half_tick && length != 6'd0 && !halt)
                                              length <= length - 6'd1;

      bus.sample <= level;
      bus.active <= (length != 6'd0);
    end
  end

endmodule

// File: tb/tb_pulse_channel.sv
// Self-checking bench for pulse_channel: vector table, directed corner sequences,
// and randomized traffic compared cycle by cycle against a behavioural model.
module tb_pulse_channel;

  localparam int MIN_P = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pulse_channel_if bus ();

  pulse_channel #(.TIMER_WIDTH(11), .MIN_PERIOD(MIN_P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state (plain integers)
  int duty_pat[4] = '{8'h02, 8'h06, 8'h1E, 8'hF9};
  int m_duty, m_halt, m_const, m_vol, m_period, m_en;
  int m_timer, m_step, m_start, m_div, m_decay, m_len;
  int m_sample, m_active;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_duty = 0; m_halt = 0; m_const = 0; m_vol = 0; m_period = 0; m_en = 0;
    m_timer = 0; m_step = 0; m_start = 0; m_div = 0; m_decay = 0; m_len = 0;
    m_sample = 0; m_active = 0;
  endtask

  task automatic model_step(input bit q, input bit h, input bit we, input int a, input int d);
    bit high;
    high     = ((duty_pat[m_duty] >> m_step) & 1) == 1;
    m_sample = (m_len == 0 || m_period < MIN_P || !high) ? 0 : (m_const != 0 ? m_vol : m_decay);
    m_active = (m_len != 0) ? 1 : 0;

    if (m_timer == 0) begin
      m_timer = m_period;
      m_step  = (m_step + 1) % 8;
    end else begin
      m_timer = m_timer - 1;
    end
    if (we && a == 2) m_step = 0;

    if (q) begin
      if (m_start != 0) begin
        m_start = 0; m_decay = 15; m_div = m_vol;
      end else if (m_div == 0) begin
        m_div = m_vol;
        if (m_decay > 0)       m_decay = m_decay - 1;
        else if (m_halt != 0)  m_decay = 15;
      end else begin
        m_div = m_div - 1;
      end
    end

    if (we && a == 3 && d % 2 == 0)       m_len = 0;
    else if (we && a == 2 && m_en != 0)   m_len = (d / 8) * 2 + 1;
    else if (h && m_len > 0 && m_halt == 0) m_len = m_len - 1;

    if (we) begin
      case (a)
        0: begin
          m_duty = d / 64; m_halt = (d / 32) % 2; m_const = (d / 16) % 2; m_vol = d % 16;
        end
        1: m_period = (m_period / 256) * 256 + d;
        2: begin m_period = (d % 8) * 256 + m_period % 256; m_start = 1; end
        default: m_en = d % 2;
      endcase
    end
  endtask

  // One clock with the given inputs; DUT outputs compared against the model.
  task automatic cyc(input bit q, input bit h, input bit we, input int a, input int d);
    bus.quarter_tick = q;
    bus.half_tick    = h;
    bus.reg_we       = we;
    bus.reg_addr     = 2'(a);
    bus.reg_data     = 8'(d);
    @(posedge clk);
    model_step(q, h, we, a, d);
    #1;
    chk("model_sample", 16'(bus.sample), 16'(m_sample));
    chk("model_active", 16'(bus.active), 16'(m_active));
    bus.quarter_tick = 1'b0;
    bus.half_tick    = 1'b0;
    bus.reg_we       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    cyc(0, 0, 1, a, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.quarter_tick = 1'b0;
    bus.half_tick    = 1'b0;
    bus.reg_we       = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    chk("reset_sample", 16'(bus.sample), 16'd0);
    chk("reset_active", 16'(bus.active), 16'd0);
  endtask

  // Runs at least one cycle, then until sample is nonzero; returns the level seen.
  task automatic wait_nonzero(input string name, output int lvl);
    int n;
    n = 0;
    do begin
      idle(1);
      n++;
    end while (bus.sample == 4'd0 && n < 300);
    if (bus.sample == 4'd0) chk({name, "_timeout"}, 16'd0, 16'd1);
    lvl = int'(bus.sample);
  endtask

  task automatic qtick(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0, 0);
      idle(1);
    end
  endtask

  task automatic htick(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, 0, 0);
      idle(1);
    end
  endtask

  typedef struct {
    bit       we;
    bit       ht;
    int       addr;
    int       data;
    int       exp_sample;
    int       exp_active;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int lvl, cnt, nz;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    bus.quarter_tick = 1'b0;
    bus.half_tick    = 1'b0;
    bus.reg_we       = 1'b0;
    bus.reg_addr     = 2'd0;
    bus.reg_data     = 8'd0;
    model_reset();

    tbl[0] = '{1, 0, 3, 8'h01, 0, 0};
    tbl[1] = '{1, 0, 0, 8'hBF, 0, 0};
    tbl[2] = '{1, 0, 1, 8'h09, 0, 0};
    tbl[3] = '{1, 0, 2, 8'h08, 0, 0};  // length loads 3
    tbl[4] = '{0, 0, 0, 8'h00, 0, 1};  // step 0 of duty2 is low
    tbl[5] = '{0, 1, 0, 8'h00, 0, 1};  // halt blocks decrement
    tbl[6] = '{1, 0, 3, 8'h00, 0, 1};
    tbl[7] = '{0, 0, 0, 8'h00, 0, 0};
    tbl[8] = '{1, 0, 2, 8'hF8, 0, 0};  // enable=0: no load
    tbl[9] = '{0, 0, 0, 8'h00, 0, 0};

    do_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(0, tbl[i].ht, tbl[i].we, tbl[i].addr, tbl[i].data);
      chk($sformatf("tbl%0d_sample", i), 16'(bus.sample), 16'(tbl[i].exp_sample));
      chk($sformatf("tbl%0d_active", i), 16'(bus.active), 16'(tbl[i].exp_active));
    end

    // Tone: period 9, duty2 -> 40 clocks at 15, 40 at 0
    do_reset();
    wr(3, 8'h01); wr(0, 8'hBF); wr(1, 8'h09); wr(2, 8'h08);
    wait_nonzero("tone_start", lvl);
    chk("tone_level", 16'(lvl), 16'd15);
    cnt = 0;
    while (bus.sample == 4'd15 && cnt < 200) begin cnt++; idle(1); end
    chk("tone_high_len", 16'(cnt), 16'd40);
    cnt = 0;
    while (bus.sample == 4'd0 && cnt < 200) begin cnt++; idle(1); end
    chk("tone_low_len", 16'(cnt), 16'd40);
    chk("tone_active", 16'(bus.active), 16'd1);

    // Reset mid-tone, then an addr2 write with enable cleared by reset
    idle(7);
    do_reset();
    wr(2, 8'h18);
    idle(1);
    chk("post_reset_active", 16'(bus.active), 16'd0);

    // Muted period
    do_reset();
    wr(3, 8'h01); wr(0, 8'hBF); wr(1, 8'h05); wr(2, 8'h08);
    nz = 0;
    for (int i = 0; i < 100; i++) begin idle(1); if (bus.sample != 4'd0) nz++; end
    chk("muted_nonzero", 16'(nz), 16'd0);
    chk("muted_active", 16'(bus.active), 16'd1);

    // Envelope decay: duty3, vol=3, halt=0
    do_reset();
    wr(3, 8'h01); wr(0, 8'hC3); wr(1, 8'h09); wr(2, 8'hF8);
    qtick(1);
    wait_nonzero("env1", lvl);  chk("env_tick1", 16'(lvl), 16'd15);
    qtick(4);
    wait_nonzero("env5", lvl);  chk("env_tick5", 16'(lvl), 16'd14);
    qtick(4);
    wait_nonzero("env9", lvl);  chk("env_tick9", 16'(lvl), 16'd13);
    qtick(52);
    nz = 0;
    for (int i = 0; i < 80; i++) begin idle(1); if (bus.sample != 4'd0) nz++; end
    chk("env_zero", 16'(nz), 16'd0);
    qtick(20);
    nz = 0;
    for (int i = 0; i < 80; i++) begin idle(1); if (bus.sample != 4'd0) nz++; end
    chk("env_hold_zero", 16'(nz), 16'd0);
    wr(0, 8'hE3);
    qtick(4);
    wait_nonzero("env_loop", lvl); chk("env_loop_15", 16'(lvl), 16'd15);

    // Length counter: 7 half ticks, then enable=0 mid-count
    do_reset();
    wr(3, 8'h01); wr(0, 8'h00); wr(1, 8'h09); wr(2, 8'h18);
    htick(6);
    chk("len_after6", 16'(bus.active), 16'd1);
    htick(1);
    chk("len_after7", 16'(bus.active), 16'd0);
    chk("len_after7_sample", 16'(bus.sample), 16'd0);
    wr(2, 8'h18);
    htick(2);
    wr(3, 8'h00);
    idle(1);
    chk("len_disable", 16'(bus.active), 16'd0);

    // Load and half_tick together: load wins
    wr(3, 8'h01);
    cyc(0, 1, 1, 2, 8'h18);
    htick(6);
    chk("load_wins_6", 16'(bus.active), 16'd1);
    htick(1);
    chk("load_wins_7", 16'(bus.active), 16'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int a, d;
      bit we, q, h;
      we = ($urandom_range(0, 7) == 0);
      a  = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 255));
      if (a == 2 && $urandom_range(0, 3) != 0) d = d & 8'hF8;
      if (a == 3 && $urandom_range(0, 3) != 0) d = d | 1;
      q  = ($urandom_range(0, 15) == 0);
      h  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc(q, h, we, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
